// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit. Contains the one-hot bit indices
// of the decoder's load/store vectors, the FSM state encoding, the access-size
// encoding and small decode helpers.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Bit positions inside load_i (one-hot {lwu,lhu,lbu,ld,lw,lh,lb})
    localparam int LD_LB  = 0;
    localparam int LD_LH  = 1;
    localparam int LD_LW  = 2;
    localparam int LD_LD  = 3;
    localparam int LD_LBU = 4;
    localparam int LD_LHU = 5;
    localparam int LD_LWU = 6;
    localparam int N_LD   = 7;

    // Bit positions inside store_i (one-hot {sd,sw,sh,sb})
    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;
    localparam int ST_SD  = 3;
    localparam int N_ST   = 4;

    // Transaction FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Access size
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } acc_size_e;

    // True when exactly one bit of the combined {store,load} vector is set
    function automatic logic is_onehot(input logic [N_LD+N_ST-1:0] v);
        logic res;
        res = (v != 11'd0) && ((v & (v - 11'd1)) == 11'd0);
        return res;
    endfunction

    // True when the byte offset is a multiple of the access size
    function automatic logic is_aligned(input acc_size_e sz, input logic [2:0] off);
        logic res;
        case (sz)
            SZ_B:    res = 1'b1;
            SZ_H:    res = (off[0] == 1'b0);
            SZ_W:    res = (off[1:0] == 2'b00);
            SZ_D:    res = (off == 3'b000);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic shared between the multi-cycle LSU and the future
// pipelined core: store byte-enable / lane replication and load extraction
// with sign or zero extension.
//   off_i       byte offset within the dword (addr[2:0])
//   size_i      access size
//   unsigned_i  1 = zero-extend loads (lbu/lhu/lwu)
//   st_data_i   raw store data (rs2)
//   ld_raw_i    aligned dword returned by memory
//   st_wstrb_o  byte enables for the store
//   st_wdata_o  store data replicated onto every lane of its size
//   ld_data_o   formatted load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off_i,
    input  acc_size_e   size_i,
    input  logic        unsigned_i,
    input  logic [63:0] st_data_i,
    input  logic [63:0] ld_raw_i,
    output logic [7:0]  st_wstrb_o,
    output logic [63:0] st_wdata_o,
    output logic [63:0] ld_data_o
);

    logic [63:0] shifted_s;

    // Lane selection and extension by access size
    always_comb begin
        // Bring the addressed byte down to lane 0 before extracting
        shifted_s = ld_raw_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B: begin
                st_wstrb_o = 8'h01 << off_i;
                st_wdata_o = {8{st_data_i[7:0]}};
                if (unsigned_i) begin
                    ld_data_o = {56'd0, shifted_s[7:0]};
                end else begin
                    ld_data_o = {{56{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                st_wstrb_o = 8'h03 << off_i;
                st_wdata_o = {4{st_data_i[15:0]}};
                if (unsigned_i) begin
                    ld_data_o = {48'd0, shifted_s[15:0]};
                end else begin
                    ld_data_o = {{48{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W: begin
                st_wstrb_o = 8'h0F << off_i;
                st_wdata_o = {2{st_data_i[31:0]}};
                if (unsigned_i) begin
                    ld_data_o = {32'd0, shifted_s[31:0]};
                end else begin
                    ld_data_o = {{32{shifted_s[31]}}, shifted_s[31:0]};
                end
            end
            SZ_D: begin
                st_wstrb_o = 8'hFF;
                st_wdata_o = st_data_i;
                ld_data_o  = shifted_s;
            end
            default: begin
                st_wstrb_o = 8'h00;
                st_wdata_o = 64'd0;
                ld_data_o  = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit behind the execute stage. Accepts one access, runs a
// request/grant + response transaction on the data-memory port, and returns a
// formatted load result together with a one-cycle done pulse. busy_o stalls
// the PC while an access is in flight.
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i, load_i,
//   store_i, addr_i,
//   wdata_i                 access request from execute
//   mem_*                   data-memory request/response port
//   busy_o                  access in flight (REQ/WAIT/DONE)
//   done_o, wen_o, err_o,
//   rdata_o                 completion pulse, write-back enable, error flag
//                           and held load result
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [N_LD-1:0]  load_i,
    input  logic [N_ST-1:0]  store_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [7:0]       mem_wstrb_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wen_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             err_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    acc_size_e       size_q;
    logic            uns_q;
    logic            we_q;
    logic            err_q;
    logic            wen_q;
    logic [XLEN-1:0] rdata_q;

    logic [N_LD+N_ST-1:0] acc_s;
    logic            req_any_s;
    logic            start_ok_s;
    acc_size_e       dec_size_s;
    logic            dec_uns_s;
    logic            resp_s;
    logic            tmo_s;
    logic [7:0]      strb_s;
    logic [63:0]     st_wdata_s;
    logic [63:0]     ld_data_s;

    lsu_align u_align (
        .off_i      (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .st_data_i  (wdata_q),
        .ld_raw_i   (mem_rdata_i),
        .st_wstrb_o (strb_s),
        .st_wdata_o (st_wdata_s),
        .ld_data_o  (ld_data_s)
    );

    // Decode the incoming access and the transaction exit conditions
    always_comb begin
        acc_s     = {store_i, load_i};
        req_any_s = in_valid_i && (acc_s != 11'd0);
        dec_uns_s = load_i[LD_LBU] | load_i[LD_LHU] | load_i[LD_LWU];
        if (load_i[LD_LB] | load_i[LD_LBU] | store_i[ST_SB]) begin
            dec_size_s = SZ_B;
        end else if (load_i[LD_LH] | load_i[LD_LHU] | store_i[ST_SH]) begin
            dec_size_s = SZ_H;
        end else if (load_i[LD_LW] | load_i[LD_LWU] | store_i[ST_SW]) begin
            dec_size_s = SZ_W;
        end else begin
            dec_size_s = SZ_D;
        end
        start_ok_s = req_any_s && is_onehot(acc_s) && is_aligned(dec_size_s, addr_i[2:0]);
        resp_s     = (state_q == S_WAIT) && mem_rvalid_i;
        // A response arriving in the last allowed cycle still wins over the abort
        tmo_s      = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                     (cnt_q == CNT_LAST) && !resp_s;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_any_s) begin
                    state_d = start_ok_s ? S_REQ : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (tmo_s) begin
                    state_d = S_DONE;
                end else if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_s || tmo_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        mem_req_o   = (state_q == S_REQ);
        done_o      = (state_q == S_DONE);
        wen_o       = (state_q == S_DONE) && wen_q;
        err_o       = (state_q == S_DONE) && err_q;
        rdata_o     = rdata_q;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
        // Loads drive no byte enables or data
        if (we_q) begin
            mem_wstrb_o = strb_s;
            mem_wdata_o = st_wdata_s;
        end else begin
            mem_wstrb_o = 8'h00;
            mem_wdata_o = 64'd0;
        end
    end

    // Timeout counter next value: counts only while a memory access is open
    always_comb begin
        if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Access latch, completion status and held load result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {XLEN{1'b0}};
            wdata_q <= {XLEN{1'b0}};
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= {XLEN{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            if (state_q == S_IDLE && start_ok_s) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                size_q  <= dec_size_s;
                uns_q   <= dec_uns_s;
                we_q    <= |store_i;
            end else if (state_q == S_IDLE && req_any_s) begin
                // Rejected access: no memory traffic, report error directly
                err_q   <= 1'b1;
                wen_q   <= 1'b0;
                rdata_q <= {XLEN{1'b0}};
            end else if (resp_s) begin
                err_q <= 1'b0;
                wen_q <= !we_q;
                // A store has no write-back value, so the result reads as zero
                if (we_q) begin
                    rdata_q <= {XLEN{1'b0}};
                end else begin
                    rdata_q <= ld_data_s;
                end
            end else if (tmo_s) begin
                err_q   <= 1'b1;
                wen_q   <= 1'b0;
                rdata_q <= {XLEN{1'b0}};
            end else begin
                err_q <= err_q;
            end
        end
    end

endmodule
